// File: rtl/display_arbiter.sv
// Round-robin owner arbitration for the shared 4-digit display, with a minimum dwell per grant.
// Optional owner idle timeout back to a blank display is built only when DISP_TIMEOUT_EN is defined.
module display_arbiter #(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned HOLD_CYCLES    = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
    parameter logic [15:0] BLANK_VAL      = 16'h0000
) (
    input  logic                     CLK100MHZ,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [16*NUM_REQ-1:0]    req_val,
    output logic [NUM_REQ-1:0]       ack,
    output logic [15:0]              disp_val,
    output logic [1:0]               disp_src,
    output logic                     disp_valid
);

    localparam int unsigned IDX_W   = (NUM_REQ > 2) ? 2 : 1;
    localparam int unsigned CNT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
`ifdef DISP_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
    localparam logic [IDX_W-1:0] LAST_RESET   = IDX_W'(NUM_REQ - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_OWN  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   src_q, src_d;
    logic [15:0]        val_q, val_d;
    logic               valid_q, valid_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] others;
    logic               owner_req;
    logic               do_grant;
    logic               do_refresh;
    logic [IDX_W-1:0]   gnt_idx;
    logic [15:0]        vals [NUM_REQ];

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_unpack
        assign vals[g] = req_val[16*g +: 16];
    end

    // First set bit of mask searching upward from last+1, wrapping at NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        logic             found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            cand = IDX_W'((int'(last) + i) % int'(NUM_REQ));
            if (!found && mask[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        src_d      = src_q;
        val_d      = val_q;
        valid_d    = valid_q;
        ack_d      = '0;
        do_grant   = 1'b0;
        do_refresh = 1'b0;
        gnt_idx    = last_q;

        // A requester being acked this cycle cannot be captured again on this edge.
        elig      = req & ~ack_q;
        others    = elig & ~(NUM_REQ'(1) << last_q);
        owner_req = elig[last_q];

        case (state_q)
            ST_IDLE: begin
                if (|elig) begin
                    do_grant = 1'b1;
                    gnt_idx  = rr_pick(elig, last_q);
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    if (|others) begin
                        do_grant = 1'b1;
                        gnt_idx  = rr_pick(others, last_q);
                    end else begin
                        state_d    = ST_OWN;
                        cnt_d      = '0;
                        do_refresh = owner_req;
                    end
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    do_refresh = owner_req;
                end
            end
            ST_OWN: begin
                if (|others) begin
                    do_grant = 1'b1;
                    gnt_idx  = rr_pick(others, last_q);
                end else if (owner_req) begin
                    do_refresh = 1'b1;
`ifdef DISP_TIMEOUT_EN
                    cnt_d      = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    val_d   = BLANK_VAL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (do_grant) begin
            state_d        = ST_HOLD;
            cnt_d          = '0;
            last_d         = gnt_idx;
            src_d          = gnt_idx;
            val_d          = vals[gnt_idx];
            valid_d        = 1'b1;
            ack_d[gnt_idx] = 1'b1;
        end

        if (do_refresh) begin
            val_d         = vals[last_q];
            ack_d[last_q] = 1'b1;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= LAST_RESET;
            src_q   <= '0;
            val_q   <= BLANK_VAL;
            valid_q <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            src_q   <= src_d;
            val_q   <= val_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
        end
    end

    assign ack        = ack_q;
    assign disp_val   = val_q;
    assign disp_src   = 2'(src_q);
    assign disp_valid = valid_q;

endmodule
